// File: rtl/hamming_decoder.sv
// Hamming(12,8) receive-side decoder: two-stage valid/ready pipeline with
// single-error correction and saturating corrected/uncorrectable counters.
module hamming_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    // Data bits sit at codeword positions 3,5,6,7,9,10,11,12 (bits 2,4..6,8..11).
    function automatic logic [7:0] extract_data(input logic [11:0] c);
        return {c[11:8], c[6:4], c[2]};
    endfunction

    logic             r_s1_valid;
    logic [11:0]      r_s1_code;
    logic [3:0]       r_s1_syn;
    logic             r_s1_hi_err;

    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic [3:0]       r_out_syndrome;
    logic             r_out_corrected;
    logic             r_out_uncorrectable;

    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;

    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_out_xfer;
    logic [3:0]       w_syn;
    logic             w_hi_err;
    logic             w_correctable;
    logic             w_uncorrectable;
    logic [11:0]      w_flip;
    logic [11:0]      w_fixed_code;

    // Ready depends only on registered state, never on in_valid.
    assign w_s2_ready = !r_out_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_syn[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6] ^ in_code[8] ^ in_code[10];
    assign w_syn[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6] ^ in_code[9] ^ in_code[10];
    assign w_syn[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6] ^ in_code[11];
    assign w_syn[3] = in_code[7] ^ in_code[8] ^ in_code[9] ^ in_code[10] ^ in_code[11];
    assign w_hi_err = |in_code[15:12];

    always_comb begin
        w_uncorrectable = r_s1_hi_err || (r_s1_syn >= 4'd13);
        w_correctable   = !w_uncorrectable && (r_s1_syn != 4'd0);
        w_flip          = '0;
        if (w_correctable) begin
            w_flip = 12'b1 << (r_s1_syn - 4'd1);
        end
        w_fixed_code = r_s1_code ^ w_flip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_code   <= '0;
            r_s1_syn    <= '0;
            r_s1_hi_err <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_code   <= in_code[11:0];
                r_s1_syn    <= w_syn;
                r_s1_hi_err <= w_hi_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid         <= 1'b0;
            r_out_data          <= '0;
            r_out_syndrome      <= '0;
            r_out_corrected     <= 1'b0;
            r_out_uncorrectable <= 1'b0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data          <= extract_data(w_fixed_code);
                r_out_syndrome      <= r_s1_syn;
                r_out_corrected     <= w_correctable;
                r_out_uncorrectable <= w_uncorrectable;
            end
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_out_corrected && !(&r_corr_cnt)) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (r_out_uncorrectable && !(&r_uncorr_cnt)) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready          = w_s1_ready;
    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_syndrome      = r_out_syndrome;
    assign out_corrected     = r_out_corrected;
    assign out_uncorrectable = r_out_uncorrectable;
    assign corr_cnt          = r_corr_cnt;
    assign uncorr_cnt        = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed vector table, backpressure,
// counter saturation/clear, random traffic against a reference model, reset mid-stream.
module tb_hamming_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    typedef struct {
        logic [15:0] code;
        exp_t        e;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_code;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       out_syndrome;
    logic             out_corrected;
    logic             out_uncorrectable;
    logic             clear_cnt;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    hamming_decoder #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_code          (in_code),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_syndrome     (out_syndrome),
        .out_corrected    (out_corrected),
        .out_uncorrectable(out_uncorrectable),
        .clear_cnt        (clear_cnt),
        .corr_cnt         (corr_cnt),
        .uncorr_cnt       (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    logic   mon_en   = 1'b0;
    exp_t   cur_exp;
    exp_t   exp_q[$];
    int     mc = 0;
    int     mu = 0;
    logic   prev_stall = 1'b0;
    logic [14:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference decode: syndrome is the XOR of the 1-based positions of all set bits.
    function automatic exp_t model(input logic [15:0] c);
        exp_t        e;
        logic [3:0]  s;
        logic [11:0] w;
        s = 4'd0;
        w = c[11:0];
        for (int i = 0; i < 12; i++) begin
            if (c[i]) s = s ^ 4'(i + 1);
        end
        e.syn  = s;
        e.unc  = (c[15:12] != 4'd0) || (s > 4'd12);
        e.corr = !e.unc && (s != 4'd0);
        if (e.corr) w[s - 4'd1] = ~w[s - 4'd1];
        e.data = {w[11], w[10], w[9], w[8], w[6], w[5], w[4], w[2]};
        return e;
    endfunction

    function automatic logic [15:0] encode(input logic [7:0] d);
        logic [11:0] w;
        logic [3:0]  s;
        w = '0;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        w[11:8] = d[7:4];
        s = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w[i]) s = s ^ 4'(i + 1);
        end
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        w[7] = s[3];
        return {4'h0, w};
    endfunction

    // Samples just before each rising edge what that edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_fields",
                    32'({out_data, out_syndrome, out_corrected, out_uncorrectable}), 32'(held));
            end
            prev_stall = out_valid && !out_ready && !rst;
            held = {out_data, out_syndrome, out_corrected, out_uncorrectable};
            chk("corr_cnt", 32'(corr_cnt), 32'(mc));
            chk("uncorr_cnt", 32'(uncorr_cnt), 32'(mu));
            if (rst) begin
                exp_q.delete();
                mc = 0;
                mu = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_output");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                        chk("out_corrected", 32'(out_corrected), 32'(e.corr));
                        chk("out_uncorrectable", 32'(out_uncorrectable), 32'(e.unc));
                        chk("flag_exclusive", 32'(out_corrected & out_uncorrectable), 32'd0);
                        if (e.corr && mc < int'(MAXC)) mc++;
                        if (e.unc && mu < int'(MAXC)) mu++;
                    end
                end
                if (clear_cnt) begin
                    mc = 0;
                    mu = 0;
                end
                if (in_valid && in_ready) exp_q.push_back(cur_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] c, input exp_t e);
        int   g;
        logic acc;
        g = 0;
        in_valid = 1'b1;
        in_code  = c;
        cur_exp  = e;
        do begin
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 100);
        if (!acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            tick(1);
            g++;
        end
        if (g >= 100) fail_now("drain_timeout");
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic [3:0] s, input logic c,
                                input logic u);
        exp_t e;
        e.data = d;
        e.syn  = s;
        e.corr = c;
        e.unc  = u;
        return e;
    endfunction

    vec_t vecs[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{code: 16'h0A27, e: mk(8'hA5, 4'd0,  1'b0, 1'b0)};
        vecs[1] = '{code: 16'h0A07, e: mk(8'hA5, 4'd6,  1'b1, 1'b0)};
        vecs[2] = '{code: 16'h0B07, e: mk(8'hB1, 4'd15, 1'b0, 1'b1)};
        vecs[3] = '{code: 16'h1A27, e: mk(8'hA5, 4'd0,  1'b0, 1'b1)};
        vecs[4] = '{code: 16'h0A24, e: mk(8'hA4, 4'd3,  1'b1, 1'b0)};
        for (int b = 0; b < 12; b++) begin
            vecs[5 + b] = '{code: 16'h0A27 ^ (16'h1 << b), e: mk(8'hA5, 4'(b + 1), 1'b1, 1'b0)};
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        clear_cnt = 1'b0;
        cur_exp   = mk(8'h00, 4'd0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
        chk("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
        chk("rst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;

        // Latency: word accepted on edge N appears after edge N+1.
        send(16'h0A27, vecs[0].e);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        tick(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'hA5);
        drain();

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].code, vecs[i].e);
        end
        drain();

        // Backpressure: two words fill the pipe, third must wait.
        out_ready = 1'b0;
        send(vecs[0].code, vecs[0].e);
        send(vecs[1].code, vecs[1].e);
        in_valid = 1'b1;
        in_code  = vecs[2].code;
        cur_exp  = vecs[2].e;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_head_data", 32'(out_data), 32'hA5);
            chk("bp_head_syn", 32'(out_syndrome), 32'd0);
            tick(1);
        end
        out_ready = 1'b1;
        send(vecs[2].code, vecs[2].e);
        send(vecs[4].code, vecs[4].e);
        drain();

        // Saturation with a 4-bit counter, then clear colliding with an increment.
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        chk("cnt_cleared", 32'(corr_cnt), 32'd0);
        for (int i = 0; i < 20; i++) send(16'h0A07, vecs[1].e);
        drain();
        chk("corr_saturated", 32'(corr_cnt), 32'd15);
        out_ready = 1'b0;
        send(16'h0A07, vecs[1].e);
        begin
            int g;
            g = 0;
            while (!out_valid && g < 10) begin
                tick(1);
                g++;
            end
            if (!out_valid) fail_now("clear_wait_timeout");
        end
        clear_cnt = 1'b1;
        out_ready = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        chk("clear_priority", 32'(corr_cnt), 32'd0);
        drain();

        // Random traffic with random backpressure.
        begin
            int   sent;
            int   guard;
            logic acc;
            sent  = 0;
            guard = 0;
            while (sent < 1000 && guard < 20000) begin
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    logic [15:0] c;
                    int          r;
                    int          b1;
                    int          b2;
                    c  = encode(8'($urandom));
                    r  = $urandom_range(0, 9);
                    b1 = $urandom_range(0, 11);
                    b2 = (b1 + $urandom_range(1, 11)) % 12;
                    if (r >= 3 && r <= 8) c[b1] = ~c[b1];
                    if (r >= 7 && r <= 8) c[b2] = ~c[b2];
                    if (r == 9) c[15:12] = 4'($urandom_range(1, 15));
                    in_valid = 1'b1;
                    in_code  = c;
                    cur_exp  = model(c);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                clear_cnt = ($urandom_range(0, 63) == 0);
                #1;
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
                guard++;
            end
            clear_cnt = 1'b0;
            in_valid  = 1'b0;
            if (sent < 1000) fail_now("random_timeout");
        end
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(vecs[1].code, vecs[1].e);
        send(vecs[2].code, vecs[2].e);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
        chk("mid_rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick(1);
        chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(16'h0B07, vecs[2].e);
        drain();
        chk("post_rst_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
        chk("post_rst_corr_cnt", 32'(corr_cnt), 32'd0);

        tick(2);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
- Receive side of the team's Hamming(12,8) single-error-correcting code. Accepts 16-bit codewords from memory or the link, computes the syndrome, corrects single-bit errors and returns the 8-bit data.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Saturating error counters for scrubbing and health telemetry.

Parameters:
- CNT_W, 16, width of the corrected and uncorrectable error counters (min 4).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  codeword present on in_code
- in_ready  output  1  decoder can accept in_code this cycle
- in_code  input  16  codeword: [0]=p0, [1]=p1, [2]=d0, [3]=p2, [4..6]=d1..d3, [7]=p3, [8..11]=d4..d7, [15:12] must be 0
- out_valid  output  1  decoded word present
- out_ready  input  1  downstream accepts the word
- out_data  output  8  corrected data d7..d0
- out_syndrome  output  4  syndrome of this word
- out_corrected  output  1  single-bit error fixed in this word
- out_uncorrectable  output  1  syndrome 13..15, or in_code[15:12] != 0
- clear_cnt  input  1  synchronous clear of both counters
- corr_cnt  output  CNT_W  saturating count of words delivered with out_corrected=1
- uncorr_cnt  output  CNT_W  saturating count of words delivered with out_uncorrectable=1

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0, corr_cnt=0, uncorr_cnt=0, both internal stage-valid flags 0. in_ready=1 from the first cycle after reset.
- Reset mid-operation drops any in-flight words. No partial output is produced.
- Transfer rule: a transfer happens on a cycle where valid and ready are both 1. out_* stays stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 word/cycle.
- Ready chaining:
  - s1_ready = !s1_valid | s2_ready
  - s2_ready = !out_valid | out_ready
  - in_ready = s1_ready
  - No combinational path from in_valid to in_ready.
- Stage 1 registers the codeword and syndrome. Bit indices refer to in_code:
  - s[0] = c0^c2^c4^c6^c8^c10
  - s[1] = c1^c2^c5^c6^c9^c10
  - s[2] = c3^c4^c5^c6^c11
  - s[3] = c7^c8^c9^c10^c11
  - It also registers hi_err = |c[15:12].
- Stage 2 (output register) classifies the word:
  - s==0 and !hi_err: data passed through, corrected=0, uncorrectable=0.
  - s in 1..12 and !hi_err: flip codeword bit s-1, then extract data; corrected=1.
  - s in 13..15 or hi_err: data is the uncorrected extraction, uncorrectable=1, corrected=0.
- Flag exclusivity: corrected and uncorrectable are never both 1.
- Double-bit errors are not detected. The code has no overall parity bit, so they are miscorrected or flagged uncorrectable depending on the syndrome. Verification must not expect detection.
- Counters increment on an output transfer when the matching flag is set.
  - They saturate at all-ones and do not wrap.
  - clear_cnt has priority over an increment in the same cycle; the result is 0.
  - rst clears both counters.

Test Plan:
- Clean word: in_code=0x0A27 -> 2 cycles later out_data=0xA5, syndrome=0, corrected=0, uncorrectable=0. Counters unchanged.
- Single error: in_code=0x0A07 (bit 5 flipped) -> out_data=0xA5, syndrome=6, corrected=1, corr_cnt increments by 1 on transfer. Sweep every bit 0..11 of 0x0A27; each gives 0xA5 with syndrome = bit+1.
- Uncorrectable:
  - in_code=0x0B07 (bits 5,8 flipped) -> syndrome=15, uncorrectable=1, uncorr_cnt+1.
  - in_code=0x1A27 -> uncorrectable=1 from hi_err.
  - Double flip of bits 0,1 (0x0A24) -> syndrome=3, out_data=0xA4 (miscorrection is the required behaviour).
- Backpressure: stream 4 words with out_ready held 0.
  - After 2 accepted words, in_ready=0 and out_* stays stable.
  - Release out_ready -> all 4 words emerge in order, none lost or duplicated.
  - Then random valid/ready toggling across 1000 random words matches a reference model.
- Counter saturation/clear: with CNT_W=4, deliver 20 corrected words -> corr_cnt=15. Assert clear_cnt in the same cycle as a corrected transfer -> corr_cnt=0.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, counters=0, in_ready=1. The first post-reset word decodes correctly.
